// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type, default width and counter-width helper
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam int SA_WIDTH = 8;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the bit-serial adder
//   master drives start, A, B, CIN; slave drives busy, done, SUM, COUT (and OVF when SERIAL_ADDER_OVF_EN is defined)
interface serial_adder_if import serial_adder_pkg::*; #(parameter int N = SA_WIDTH);
  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         CIN;
  logic         busy;
  logic         done;
  logic [N-1:0] SUM;
  logic         COUT;
`ifdef SERIAL_ADDER_OVF_EN
  logic         OVF;
  modport master (output start, A, B, CIN, input busy, done, SUM, COUT, OVF);
  modport slave  (input start, A, B, CIN, output busy, done, SUM, COUT, OVF);
`else
  modport master (output start, A, B, CIN, input busy, done, SUM, COUT);
  modport slave  (input start, A, B, CIN, output busy, done, SUM, COUT);
`endif
endinterface

// File: rtl/fulladder.sv
// fulladder: single-bit full adder
//   X, Y, Z: addend bits and carry-in; S: sum bit; C: carry-out
module fulladder (
  input  logic X,
  input  logic Y,
  input  logic Z,
  output logic S,
  output logic C
);
  assign S = X ^ Y ^ Z;
  assign C = (X & Y) | (Z & (X ^ Y));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder, one bit per clock LSB first, using one fulladder
//   clk, rst_n (async active-low); sa: slave side of serial_adder_if
//   optional OVF output (signed overflow) when SERIAL_ADDER_OVF_EN is defined
module serial_adder import serial_adder_pkg::*; #(
  parameter int N = SA_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  serial_adder_if.slave   sa
);
  localparam int CW = cnt_w(N);
  state_t          r_state, w_next;
  logic [N-1:0]    r_a, r_b, r_sum;
  logic [N-2:0]    r_s;
  logic            r_carry, r_cout;
  logic [CW-1:0]   r_cnt;
  logic            w_s, w_c, w_last;
  fulladder u_fa (.X(r_a[0]), .Y(r_b[0]), .Z(r_carry), .S(w_s), .C(w_c));
  assign w_last = r_cnt == CW'(N - 1);
  always_comb begin
    w_next = (r_state == IDLE)  ? (sa.start ? SHIFT : IDLE) :
             (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end
`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  assign sa.OVF = r_ovf;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else if (r_state == IDLE && sa.start) begin
      r_a     <= sa.A;
      r_b     <= sa.B;
      r_carry <= sa.CIN;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      // sum bits enter at the top so the word is LSB-aligned after N shifts
      r_s     <= (N-1)'({w_s, r_s} >> 1);
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= {w_s, r_s};
        r_cout <= w_c;
`ifdef SERIAL_ADDER_OVF_EN
        // r_carry is the carry into the MSB while the MSB is being added
        r_ovf  <= r_carry ^ w_c;
`endif
      end
    end
  end
  assign sa.busy = r_state == SHIFT;
  assign sa.done = r_state == DONE;
  assign sa.SUM  = r_sum;
  assign sa.COUT = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder with N=8
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;
  logic [7:0] prev_sum;
  logic       prev_cout;
  always #5 clk = ~clk;
  serial_adder_if #(.N(8)) sa ();
  serial_adder #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .sa(sa));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic [8:0] exp);
    int busy_n = 0;
    int k = 0;
    logic stable = 1'b1;
    logic both = 1'b0;
    @(negedge clk);
    sa.A = a; sa.B = b; sa.CIN = cin; sa.start = 1'b1;
    @(negedge clk);
    sa.start = 1'b0; sa.A = ~a; sa.B = ~b; sa.CIN = ~cin;
    while (sa.done !== 1'b1 && k < 20) begin
      if (sa.busy === 1'b1) busy_n++;
      if (sa.SUM !== prev_sum || sa.COUT !== prev_cout) stable = 1'b0;
      @(negedge clk);
      k++;
    end
    if (sa.busy === 1'b1 && sa.done === 1'b1) both = 1'b1;
    check("done_seen", sa.done, 1);
    check("busy_cycles", busy_n, 8);
    check("held_stable", stable, 1);
    check("busy_done_excl", both, 0);
    check("sum", sa.SUM, exp[7:0]);
    check("cout", sa.COUT, exp[8]);
`ifdef SERIAL_ADDER_OVF_EN
    begin
      logic [7:0] low;
      low = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, cin};
      check("ovf", sa.OVF, low[7] ^ exp[8]);
    end
`endif
    prev_sum = sa.SUM;
    prev_cout = sa.COUT;
    @(negedge clk);
    check("done_one_cycle", sa.done, 0);
  endtask

  initial begin
    logic [7:0] v [4];
    int dcount;
    logic any_done;
    v = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    rst_n = 1'b0;
    sa.start = 1'b0; sa.A = '0; sa.B = '0; sa.CIN = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", sa.busy, 0);
    check("rst_done", sa.done, 0);
    check("rst_sum", sa.SUM, 0);
    check("rst_cout", sa.COUT, 0);
    rst_n = 1'b1;
    prev_sum = 8'h00;
    prev_cout = 1'b0;
    do_op(8'h0F, 8'h01, 1'b0, 9'h010);
    do_op(8'hFF, 8'h01, 1'b0, 9'h100);
    do_op(8'h00, 8'h00, 1'b1, 9'h001);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        for (int c = 0; c < 2; c++)
          do_op(v[i], v[j], c[0], {1'b0, v[i]} + {1'b0, v[j]} + 9'(c));
    @(negedge clk);
    sa.A = 8'h12; sa.B = 8'h34; sa.CIN = 1'b0; sa.start = 1'b1;
    @(negedge clk);
    sa.start = 1'b0;
    repeat (2) @(negedge clk);
    sa.A = 8'hFF; sa.start = 1'b1;
    @(negedge clk);
    sa.start = 1'b0;
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      if (sa.done === 1'b1) dcount++;
      @(negedge clk);
    end
    check("ignored_start_dones", dcount, 1);
    check("ignored_start_sum", sa.SUM, 8'h46);
    check("ignored_start_cout", sa.COUT, 0);
    check("ignored_start_idle", sa.busy, 0);
    @(negedge clk);
    sa.A = 8'hF0; sa.B = 8'h0F; sa.CIN = 1'b0; sa.start = 1'b1;
    @(negedge clk);
    sa.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", sa.busy, 0);
    check("abort_sum", sa.SUM, 0);
    check("abort_cout", sa.COUT, 0);
    any_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (sa.done !== 1'b0) any_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (sa.done !== 1'b0 || sa.busy !== 1'b0) any_done = 1'b1;
    end
    check("abort_no_done", any_done, 0);
    prev_sum = 8'h00;
    prev_cout = 1'b0;
    do_op(8'h01, 8'h02, 1'b0, 9'h003);
`ifdef SERIAL_ADDER_OVF_EN
    do_op(8'h7F, 8'h01, 1'b0, 9'h080);
    check("ovf_7f_01", sa.OVF, 1);
    do_op(8'h80, 8'h80, 1'b0, 9'h100);
    check("ovf_80_80", sa.OVF, 1);
    do_op(8'hFF, 8'h01, 1'b0, 9'h100);
    check("ovf_ff_01", sa.OVF, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
